// File: rtl/program_loader.sv
// program_loader: streams DEPTH bytes over valid/ready into the program RAM, tracking count and checksum.
// Optional read-back verify pass when PROGRAM_LOADER_VERIFY_EN is defined; all outputs registered.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_byte_valid,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_byte_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_program_mode,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data_program,
  output logic              o_write_enable,
  output logic              o_read_enable,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_count,
  output logic [DATA_W-1:0] o_checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_VREAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   csum_q;
  logic                pm_q;
  logic                rdy_q;
  logic                we_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic                re_q;
  logic [DATA_W-1:0]   vsum_q;
  logic [DATA_W-1:0]   vsum_d;

  assign vsum_d = vsum_q + i_data;
`else
  logic unused_rdata;

  assign unused_rdata = ^i_data;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      csum_q  <= '0;
      pm_q    <= 1'b0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
      re_q    <= 1'b0;
      vsum_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A simultaneous abort suppresses the start.
          if (i_start && !i_abort) begin
            state_q <= S_ACCEPT;
            addr_q  <= '0;
            count_q <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            pm_q    <= 1'b1;
            rdy_q   <= 1'b1;
          end
        end

        S_ACCEPT: begin
          if (i_abort) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            pm_q    <= 1'b0;
            rdy_q   <= 1'b0;
          end else if (i_byte_valid) begin
            state_q <= S_WRITE;
            data_q  <= i_byte;
            csum_q  <= csum_q + i_byte;
            rdy_q   <= 1'b0;
            we_q    <= 1'b1;
          end
        end

        S_WRITE: begin
          // The strobe was asserted this cycle, so the byte counts even on abort.
          count_q <= count_q + CNT_ONE;
          we_q    <= 1'b0;
          if (i_abort) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            pm_q    <= 1'b0;
          end else if (addr_q == LAST_ADDR) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
            state_q <= S_VREAD;
            addr_q  <= '0;
            pm_q    <= 1'b0;
            re_q    <= 1'b1;
            vsum_q  <= '0;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pm_q    <= 1'b0;
`endif
          end else begin
            state_q <= S_ACCEPT;
            addr_q  <= addr_q + ADDR_ONE;
            rdy_q   <= 1'b1;
          end
        end

`ifdef PROGRAM_LOADER_VERIFY_EN
        S_VREAD: begin
          vsum_q <= vsum_d;
          if (i_abort) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            re_q    <= 1'b0;
          end else if (addr_q == LAST_ADDR) begin
            state_q <= S_DONE;
            re_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= (vsum_d != csum_q);
          end else begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_program_mode = pm_q;
  assign o_byte_ready   = rdy_q;
  assign o_address      = addr_q;
  assign o_data_program = data_q;
  assign o_write_enable = we_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = err_q;
  assign o_count        = count_q;
  assign o_checksum     = csum_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
  assign o_read_enable  = re_q;
`else
  assign o_read_enable  = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of full loads, hand-written abort/reset sequences and randomized loads
// checked against a byte-list/checksum model; a behavioural RAM serves the read-back bus.
module tb_program_loader;

`ifdef PROGRAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_start, i_abort, i_byte_valid;
  logic [7:0] i_byte, i_data;
  logic       o_byte_ready, o_program_mode, o_write_enable, o_read_enable;
  logic       o_busy, o_done, o_error;
  logic [3:0] o_address;
  logic [7:0] o_data_program, o_checksum;
  logic [4:0] o_count;

  always #5 i_clk = ~i_clk;

  program_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
    .i_data(i_data), .o_program_mode(o_program_mode), .o_address(o_address),
    .o_data_program(o_data_program), .o_write_enable(o_write_enable),
    .o_read_enable(o_read_enable), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_count(o_count), .o_checksum(o_checksum)
  );

  // Behavioural RAM plus write/read monitors, sampled mid-cycle.
  logic [7:0] mem [16];
  logic       corrupt7 = 1'b0;
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         rd_cnt = 0;

  assign i_data = !o_read_enable ? 8'h00 :
                  (corrupt7 && o_address == 4'd7) ? 8'hFF : mem[o_address];

  always @(negedge i_clk) begin
    if (o_write_enable) begin
      wr_addr_q.push_back(o_address);
      wr_data_q.push_back(o_data_program);
      mem[o_address] = o_data_program;
    end
    if (o_read_enable) rd_cnt++;
  end

  typedef struct {
    logic [7:0] first;
    logic [7:0] step;
    int         gap_idx;
    int         gap_len;
    int         start_at;
    bit         corrupt;
    logic [7:0] exp_csum;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] ld [16];
  int         n_vec = 0, n_err = 0;
  int         wr_base = 0, rd_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] outs_vec();
    return {o_byte_ready, o_program_mode, o_address, o_data_program, o_write_enable,
            o_read_enable, o_busy, o_done, o_error, o_count, o_checksum};
  endfunction

  function automatic logic [7:0] model_sum(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + ld[i];
    return s;
  endfunction

  task automatic start_load();
    wr_base = wr_addr_q.size();
    rd_base = rd_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Hand over n bytes, then idle until the loader is back in its accept phase.
  task automatic feed(input int n);
    int  k = 0, guard = 0;
    bit  hs;
    while ((k < n || !o_byte_ready) && guard < 100) begin
      i_byte_valid = (k < n);
      i_byte       = ld[k < 16 ? k : 15];
      hs           = o_byte_ready && i_byte_valid;
      tick();
      guard++;
      if (hs) k++;
    end
    i_byte_valid = 1'b0;
    chk("feed_timeout", 32'(guard < 100), 32'd1);
  endtask

  task automatic run_load(input int gap_idx, input int gap_len, input int start_at,
                          input bit rand_valid, output int cyc);
    int k, gl;
    bit hs, in_gap, pulsed;
    start_load();
    k = 0; gl = gap_len; cyc = 0; pulsed = 1'b0;
    while (!o_done && cyc < 200) begin
      in_gap = (k == gap_idx) && (gl > 0) && o_byte_ready;
      if (in_gap) gl--;
      i_byte_valid = (k < 16) && !in_gap && (!rand_valid || $urandom_range(3) != 0);
      i_byte       = ld[k < 16 ? k : 15];
      i_start      = (k == start_at) && !pulsed;
      if (i_start) pulsed = 1'b1;
      hs = o_byte_ready && i_byte_valid;
      tick();
      cyc++;
      i_start = 1'b0;
      if (hs) k++;
      if (in_gap) begin
        chk("gap_ready_held", 32'(o_byte_ready), 32'd1);
        chk("gap_no_write", 32'(o_write_enable), 32'd0);
      end
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic check_load(input int cyc, input int exp_cyc, input logic [7:0] exp_csum);
    logic [7:0] sum, rsum;
    int         nw;
    sum  = model_sum(16);
    rsum = sum;
    if (corrupt7) rsum = sum - ld[7] + 8'hFF;
    if (exp_cyc >= 0) chk("load_cycles", 32'(cyc), 32'(exp_cyc));
    nw = wr_addr_q.size() - wr_base;
    chk("write_pulses", 32'(nw), 32'd16);
    for (int i = 0; i < 16 && i < nw; i++) begin
      chk("write_addr", 32'(wr_addr_q[wr_base + i]), 32'(i));
      chk("write_data", 32'(wr_data_q[wr_base + i]), 32'(ld[i]));
    end
    chk("read_pulses", 32'(rd_cnt - rd_base), VERIFY ? 32'd16 : 32'd0);
    chk("done", 32'(o_done), 32'd1);
    chk("busy_after", 32'(o_busy), 32'd0);
    chk("pmode_after", 32'(o_program_mode), 32'd0);
    chk("count", 32'(o_count), 32'd16);
    chk("checksum_model", 32'(o_checksum), 32'(sum));
    chk("checksum_table", 32'(o_checksum), 32'(exp_csum));
    chk("error", 32'(o_error), 32'(VERIFY && (rsum != sum)));
    chk("addr_hold", 32'(o_address), 32'd15);
    chk("data_hold", 32'(o_data_program), 32'(ld[15]));
  endtask

  initial begin
    int cyc;
    tbl[0] = '{8'h10, 8'h01, -1, 0, -1, 1'b0, 8'h78};
    tbl[1] = '{8'h10, 8'h01,  5, 3, -1, 1'b0, 8'h78};
    tbl[2] = '{8'h05, 8'h07, -1, 0,  8, 1'b0, 8'h98};
    tbl[3] = '{8'hFF, 8'h00,  0, 2, -1, 1'b0, 8'hF0};
    tbl[4] = '{8'h10, 8'h01, -1, 0, -1, 1'b1, 8'h78};

    // Reset with random inputs for two edges.
    i_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_start = 1'($urandom); i_abort = 1'($urandom);
      i_byte_valid = 1'($urandom); i_byte = 8'($urandom);
      tick();
    end
    chk("reset_outputs", outs_vec(), 32'd0);
    i_rst_n = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
    tick();
    chk("idle_quiet", outs_vec(), 32'd0);

    // Table of complete loads.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) ld[i] = tbl[t].first + 8'(tbl[t].step * i);
      corrupt7 = tbl[t].corrupt;
      run_load(tbl[t].gap_idx, tbl[t].gap_len, tbl[t].start_at, 1'b0, cyc);
      check_load(cyc, (VERIFY ? 48 : 32) + tbl[t].gap_len, tbl[t].exp_csum);
      if (t == 0) begin
        for (int i = 0; i < 3; i++) tick();
        chk("done_holds", 32'(o_done), 32'd1);
        chk("count_holds", 32'(o_count), 32'd16);
      end
    end
    corrupt7 = 1'b0;
    for (int i = 0; i < 16; i++) ld[i] = 8'h10 + 8'(i);

    // Abort together with start after three writes.
    start_load();
    feed(3);
    i_abort = 1'b1; i_start = 1'b1; i_byte_valid = 1'b1; i_byte = ld[3];
    tick();
    i_abort = 1'b0; i_start = 1'b0;
    chk("abort_error", 32'(o_error), 32'd1);
    chk("abort_count", 32'(o_count), 32'd3);
    chk("abort_pmode", 32'(o_program_mode), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_ready", 32'(o_byte_ready), 32'd0);
    chk("abort_csum", 32'(o_checksum), 32'(model_sum(3)));
    for (int i = 0; i < 4; i++) tick();
    i_byte_valid = 1'b0;
    chk("abort_no_more_writes", 32'(wr_addr_q.size() - wr_base), 32'd3);
    chk("abort_stays_idle", 32'(o_busy), 32'd0);

    // Abort landing on a write strobe still counts that byte.
    start_load();
    chk("restart_clears_error", 32'(o_error), 32'd0);
    feed(2);
    i_byte_valid = 1'b1; i_byte = ld[2];
    tick();
    i_byte_valid = 1'b0; i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("wabort_count", 32'(o_count), 32'd3);
    chk("wabort_error", 32'(o_error), 32'd1);
    chk("wabort_strobe_drop", 32'(o_write_enable), 32'd0);
    chk("wabort_writes", 32'(wr_addr_q.size() - wr_base), 32'd3);

    // Reset in the middle of a load.
    start_load();
    feed(5);
    i_rst_n = 1'b0; i_byte_valid = 1'($urandom); i_byte = 8'($urandom);
    tick();
    chk("midload_reset", outs_vec(), 32'd0);
    i_rst_n = 1'b1; i_byte_valid = 1'b0;
    tick();
    chk("after_reset_idle", outs_vec(), 32'd0);

    // Randomized loads: random bytes, sporadic valid, a stray start pulse.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) ld[i] = 8'($urandom);
      corrupt7 = 1'($urandom);
      run_load(-1, 0, $urandom_range(15), 1'b1, cyc);
      chk("rand_finished", 32'(cyc < 200), 32'd1);
      check_load(cyc, -1, model_sum(16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequenced front-end for the 16-byte program RAM. It sits directly upstream of the RAM and drives its programming-side inputs: program-mode select, address, programming data and write/read enables. It accepts a stream of bytes over a valid/ready handshake and writes them to consecutive RAM addresses 0..15. It then reports completion, a running checksum and, optionally, a read-back verification result.

## Interface
- ADDR_W, 4, RAM address width.
- DATA_W, 8, byte width.
- DEPTH, 16, bytes per load (2**ADDR_W).
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  begin a load (honoured only in IDLE or DONE).
- i_abort  in  1  cancel a load in progress.
- i_byte_valid  in  1  i_byte holds a byte.
- i_byte  in  DATA_W  next program byte.
- o_byte_ready  out  1  loader can take a byte this cycle.
- i_data  in  DATA_W  RAM read-back (the io_data bus).
- o_program_mode  out  1  RAM manual-program select.
- o_address  out  ADDR_W  RAM address.
- o_data_program  out  DATA_W  RAM programming data.
- o_write_enable  out  1  RAM write strobe.
- o_read_enable  out  1  RAM read strobe (verify only).
- o_busy  out  1  load or verify in progress.
- o_done  out  1  load finished.
- o_error  out  1  abort or verify mismatch.
- o_count  out  ADDR_W+1  bytes written, 0..16.
- o_checksum  out  DATA_W  sum of written bytes, mod 256.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- States: IDLE, ACCEPT, WRITE, VREAD (macro only), DONE.
- IDLE/DONE + i_start:
  - go to ACCEPT.
  - Clear o_address, o_count, o_checksum, o_done and o_error.
  - Set o_busy.
- ACCEPT:
  - o_program_mode=1 and o_byte_ready=1.
  - On an edge with i_byte_valid=1, latch i_byte into o_data_program, add it to o_checksum (8-bit wrap) and go to WRITE.
  - While i_byte_valid=0, stay in ACCEPT with no strobe.
- WRITE:
  - o_program_mode=1, o_write_enable=1 for exactly one cycle, o_byte_ready=0.
  - At cycle end, o_count+1.
  - If o_address==DEPTH-1, go to DONE (or VREAD with the macro). Otherwise o_address+1 and go to ACCEPT.
- DONE:
  - o_done=1, o_busy=0, o_program_mode=0.
  - o_address and o_data_program hold their last values.
  - Outputs hold until i_start.
- i_abort in ACCEPT, WRITE or VREAD:
  - Next state is IDLE, with o_error=1 and o_busy=0.
  - All strobes and o_program_mode drop at that edge.
  - o_count holds the bytes already written.
  - A WRITE strobe already asserted in the abort cycle counts as written.
- i_abort in IDLE/DONE: ignored.
- i_start while busy: ignored.
- i_start and i_abort in the same cycle: abort wins.
- i_rst_n low at an edge overrides everything, mid-load included, and returns all outputs to 0.

## Timing
- Throughput: at most one byte per 2 cycles (ACCEPT→WRITE).
- Full load with continuous valid: 32 cycles from the first ACCEPT cycle to o_done=1.
- Byte handshake completes on an edge where o_byte_ready && i_byte_valid.
- o_address and o_data_program are stable for the whole o_write_enable cycle.
- Address wrap: o_address never increments past DEPTH-1. The load terminates instead.
- o_count reaches 16 in the same edge that enters DONE/VREAD.

## Configuration
- Macro PROGRAM_LOADER_VERIFY_EN.
- Defined:
  - After the last WRITE, enter VREAD with o_address=0 and o_program_mode=0.
  - Each VREAD cycle sets o_read_enable=1 and samples i_data at cycle end into a second 8-bit sum, then o_address+1.
  - After address DEPTH-1 is read, go to DONE. o_error=1 if the read-back sum ≠ o_checksum.
  - Verify adds 16 cycles, so a full load plus verify takes 48 cycles.
- Undefined:
  - No VREAD state. WRITE goes straight to DONE.
  - o_read_enable is tied 0, and o_error is set only by abort.

## Test plan
- Reset: hold i_rst_n=0 for 2 edges with random inputs → every output 0, o_byte_ready=0.
- Full load: i_start, then bytes 0x10..0x1F with valid held high:
  - exactly 16 write pulses at addresses 0..15 with matching data;
  - o_done=1 after 32 cycles (48 with macro);
  - o_count=16, o_checksum=0x78, o_error=0.
- Gapped valid: drop i_byte_valid for 3 cycles before byte 5 → o_byte_ready stays 1, no o_write_enable, byte 5 is written to address 5 once valid returns.
- Abort and reset mid-load:
  - After 3 writes, pulse i_abort (plus i_start in the same cycle) → IDLE, o_error=1, o_count=3, o_program_mode=0 next edge, no further writes.
  - Separately, drop i_rst_n after 5 bytes → all outputs 0.
- Start while busy: pulse i_start during byte 8 → no effect, load completes normally.
- Verify (macro on): behavioural RAM returns 0xFF at address 7 on read-back → o_done=1 with o_error=1; the unmodified RAM gives o_error=0.
